stream_mux_nto1: RTL and testbench

//   Parametrised N-to-1 valid/ready stream multiplexer with one registered output stage.

---
 rtl/stream_mux_pkg.sv | 11 +
 rtl/stream_mux_nto1_if.sv | 31 +++
 rtl/stream_mux_nto1_rr_arbiter.sv | 37 +++
 rtl/stream_mux_nto1.sv | 137 +++++++++++++
 tb/tb_stream_mux_nto1.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/stream_mux_pkg.sv
// Shared constants for the N-to-1 stream multiplexer: arbitration modes and output-stage states.
package stream_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  typedef logic [0:0] out_state_t;
  localparam out_state_t ST_EMPTY = 1'b0;
  localparam out_state_t ST_FULL  = 1'b1;

endpackage

// File: rtl/stream_mux_nto1_if.sv
// Stream bundle for stream_mux_nto1: N_CH source channels in, one tagged stream out.
// STREAM_MUX_LOCK_EN adds the s_last/m_last packet delimiters.
interface stream_mux_nto1_if #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 8
);
  localparam int SEL_W = $clog2(N_CH);

  logic [N_CH-1:0]        s_valid;
  logic [N_CH*DATA_W-1:0] s_data;
  logic [N_CH-1:0]        s_ready;
  logic                   m_valid;
  logic [DATA_W-1:0]      m_data;
  logic [SEL_W-1:0]       m_ch;
  logic                   m_ready;
`ifdef STREAM_MUX_LOCK_EN
  logic [N_CH-1:0]        s_last;
  logic                   m_last;

  modport slave  (input  s_valid, s_data, s_last, m_ready,
                  output s_ready, m_valid, m_data, m_ch, m_last);
  modport master (output s_valid, s_data, s_last, m_ready,
                  input  s_ready, m_valid, m_data, m_ch, m_last);
`else
  modport slave  (input  s_valid, s_data, m_ready,
                  output s_ready, m_valid, m_data, m_ch);
  modport master (output s_valid, s_data, m_ready,
                  input  s_ready, m_valid, m_data, m_ch);
`endif

endinterface

// File: rtl/stream_mux_nto1_rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after ptr_i, wrapping at N_CH-1.
module rr_arbiter #(
  parameter  int N_CH  = 4,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req_i,
  input  logic [SEL_W-1:0] ptr_i,
  output logic [N_CH-1:0]  grant_o,
  output logic [SEL_W-1:0] idx_o,
  output logic             any_o
);

  localparam logic [SEL_W:0] N_CH_W = (SEL_W+1)'(N_CH);

  logic [SEL_W:0]   sum;
  logic [SEL_W-1:0] cand;

  // NOTE: every output and temporary gets a default first so no path infers a latch.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    sum     = '0;
    cand    = '0;
    for (int off = 0; off < N_CH; off++) begin
      sum = {1'b0, ptr_i} + (SEL_W+1)'(off);
      if (sum >= N_CH_W) sum = sum - N_CH_W;
      cand = sum[SEL_W-1:0];
      if (!any_o && req_i[cand]) begin
        any_o = 1'b1;
        idx_o = cand;
      end
    end
    grant_o = any_o ? (N_CH'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/stream_mux_nto1.sv
// N-to-1 valid/ready stream mux, fixed-select or round-robin, with one registered output stage.
// STREAM_MUX_LOCK_EN holds the grant on one channel until a beat with s_last=1 is transferred.
module stream_mux_nto1
  import stream_mux_pkg::*;
#(
  parameter  int N_CH   = 4,
  parameter  int DATA_W = 8,
  localparam int SEL_W  = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  stream_mux_nto1_if.slave io
);

  localparam logic [SEL_W:0]   N_CH_W = (SEL_W+1)'(N_CH);
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH-1);

  out_state_t        state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [SEL_W-1:0]  ch_q, ch_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;

  logic [N_CH-1:0]   rr_grant, grant;
  logic [SEL_W-1:0]  rr_idx, g_idx, lock_ch;
  logic              rr_any, any_grant, locked, lock_mode, eff_mode;
  logic              sel_in_range, load_en, xfer, pkt_end;
  logic [DATA_W-1:0] data_sel;

  rr_arbiter #(.N_CH(N_CH)) u_rr_arbiter (
    .req_i  (io.s_valid),
    .ptr_i  (ptr_q),
    .grant_o(rr_grant),
    .idx_o  (rr_idx),
    .any_o  (rr_any)
  );

`ifdef STREAM_MUX_LOCK_EN
  logic             lock_q, lock_mode_q, last_q, last_sel;
  logic [SEL_W-1:0] lock_ch_q;

  assign locked    = lock_q;
  assign lock_ch   = lock_ch_q;
  assign lock_mode = lock_mode_q;
  assign last_sel  = |(grant & io.s_last);
  assign pkt_end   = last_sel;
  assign io.m_last = last_q;

  // A transfer without s_last pins the grant (and the mode it was won under) to that channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q      <= 1'b0;
      lock_ch_q   <= '0;
      lock_mode_q <= MODE_FIXED;
      last_q      <= 1'b0;
    end else if (xfer) begin
      lock_q      <= !last_sel;
      lock_ch_q   <= g_idx;
      lock_mode_q <= eff_mode;
      last_q      <= last_sel;
    end
  end
`else
  assign locked    = 1'b0;
  assign lock_ch   = '0;
  assign lock_mode = MODE_FIXED;
  assign pkt_end   = 1'b1;
`endif

  assign sel_in_range = ({1'b0, sel} < N_CH_W);

  always_comb begin
    eff_mode  = locked ? lock_mode : mode;
    g_idx     = '0;
    any_grant = 1'b0;
    if (locked) begin
      g_idx     = lock_ch;
      any_grant = io.s_valid[lock_ch];
    end else if (mode == MODE_RR) begin
      g_idx     = rr_idx;
      any_grant = rr_any;
    end else begin
      g_idx     = sel;
      any_grant = sel_in_range && io.s_valid[sel];
    end
    grant = (!locked && mode == MODE_RR) ? rr_grant
                                         : ({N_CH{any_grant}} & (N_CH'(1) << g_idx));
  end

  always_comb begin
    data_sel = '0;
    for (int i = 0; i < N_CH; i++)
      if (grant[i]) data_sel = io.s_data[i*DATA_W +: DATA_W];
  end

  assign load_en    = (state_q == ST_EMPTY) | io.m_ready;
  assign xfer       = load_en & any_grant;
  // Nothing is accepted while reset is asserted, even though the stage reads as empty.
  assign io.s_ready = (rst_n & load_en) ? grant : '0;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    ch_d    = ch_q;
    ptr_d   = ptr_q;
    if (xfer) begin
      state_d = ST_FULL;
      data_d  = data_sel;
      ch_d    = g_idx;
    end else if (io.m_ready) begin
      state_d = ST_EMPTY;
    end
    if (xfer && eff_mode == MODE_RR && pkt_end)
      ptr_d = (g_idx == LAST_CH) ? '0 : g_idx + SEL_W'(1);
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      ch_q    <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      ptr_q   <= ptr_d;
    end
  end

  assign io.m_valid = (state_q == ST_FULL);
  assign io.m_data  = data_q;
  assign io.m_ch    = ch_q;

endmodule

// File: tb/tb_stream_mux_nto1.sv
// Self-checking bench for stream_mux_nto1 (N_CH=4, DATA_W=8): directed table, reset, random vs model.
module tb_stream_mux_nto1;

  localparam int N = 4;
  localparam int W = 8;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       mode  = 1'b0;
  logic [1:0] sel   = 2'd0;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  stream_mux_nto1_if #(.N_CH(N), .DATA_W(W)) bus ();

  stream_mux_nto1 #(.N_CH(N), .DATA_W(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .mode (mode),
    .sel  (sel),
    .io   (bus)
  );

  typedef struct {
    logic       md;
    logic [1:0] sl;
    logic [3:0] v;
    logic       mr;
    logic [3:0] exp_rdy;
    logic       exp_mv;
    logic [1:0] exp_ch;
    logic [7:0] exp_data;
  } vec_t;

  vec_t tbl[22];

  // Behavioural reference state
  bit       m_mv;
  int       m_ch;
  int       m_ptr;
  bit [7:0] m_data;
  bit [7:0] chan_data[N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int model_grant(bit md, int sl, bit [3:0] v, int ptr);
    if (md == 1'b0) return (sl < N && v[sl]) ? sl : -1;
    for (int k = 0; k < N; k++)
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic drive_data();
    for (int i = 0; i < N; i++) bus.s_data[i*W +: W] = chan_data[i];
  endtask

  initial begin
    int  g;
    bit  load;
    bit [3:0] exp_rdy;

    bus.s_valid = '0;
    bus.m_ready = 1'b0;
    bus.s_data  = '0;
`ifdef STREAM_MUX_LOCK_EN
    bus.s_last  = '1;
`endif
    for (int i = 0; i < N; i++) chan_data[i] = 8'hA0 + 8'(i);
    drive_data();

    //            md   sl    v      mr    rdy     mv    ch    data
    tbl[0]  = '{1'b0, 2'd2, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2};
    tbl[1]  = '{1'b0, 2'd2, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2};
    tbl[2]  = '{1'b0, 2'd2, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2};
    tbl[3]  = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0};
    tbl[4]  = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1};
    tbl[5]  = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2};
    tbl[6]  = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hA3};
    tbl[7]  = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0};
    tbl[8]  = '{1'b1, 2'd0, 4'h2, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1};
    tbl[9]  = '{1'b1, 2'd0, 4'hA, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hA3};
    tbl[10] = '{1'b1, 2'd0, 4'hA, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1};
    tbl[11] = '{1'b1, 2'd0, 4'hA, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hA3};
    tbl[12] = '{1'b1, 2'd0, 4'hF, 1'b0, 4'b0000, 1'b1, 2'd3, 8'hA3};
    tbl[13] = '{1'b1, 2'd0, 4'hF, 1'b0, 4'b0000, 1'b1, 2'd3, 8'hA3};
    tbl[14] = '{1'b1, 2'd0, 4'hF, 1'b0, 4'b0000, 1'b1, 2'd3, 8'hA3};
    tbl[15] = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0};
    tbl[16] = '{1'b0, 2'd1, 4'hD, 1'b1, 4'b0000, 1'b0, 2'd0, 8'hA0};
    tbl[17] = '{1'b0, 2'd1, 4'h2, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1};
    tbl[18] = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1};
    tbl[19] = '{1'b1, 2'd0, 4'h0, 1'b1, 4'b0000, 1'b0, 2'd1, 8'hA1};
    tbl[20] = '{1'b1, 2'd0, 4'h1, 1'b0, 4'b0001, 1'b1, 2'd0, 8'hA0};
    tbl[21] = '{1'b1, 2'd0, 4'h1, 1'b0, 4'b0000, 1'b1, 2'd0, 8'hA0};

    #12;
    check("por_m_valid", 32'(bus.m_valid), 0);
    check("por_m_data",  32'(bus.m_data),  0);
    check("por_m_ch",    32'(bus.m_ch),    0);
    check("por_s_ready", 32'(bus.s_ready), 0);
    @(negedge clk) rst_n = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      mode = tbl[i].md; sel = tbl[i].sl;
      bus.s_valid = tbl[i].v; bus.m_ready = tbl[i].mr;
      #1 check($sformatf("tbl%0d_s_ready", i), 32'(bus.s_ready), 32'(tbl[i].exp_rdy));
      @(posedge clk); #1;
      check($sformatf("tbl%0d_m_valid", i), 32'(bus.m_valid), 32'(tbl[i].exp_mv));
      check($sformatf("tbl%0d_m_ch", i),    32'(bus.m_ch),    32'(tbl[i].exp_ch));
      check($sformatf("tbl%0d_m_data", i),  32'(bus.m_data),  32'(tbl[i].exp_data));
    end

    // Reset in the middle of a held beat
    @(negedge clk);
    mode = 1'b0; sel = 2'd3; bus.s_valid = 4'hF; bus.m_ready = 1'b1;
    @(posedge clk); #1;
    bus.m_ready = 1'b0;
    check("pre_rst_m_ch", 32'(bus.m_ch), 3);
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    check("rst_m_valid", 32'(bus.m_valid), 0);
    check("rst_m_data",  32'(bus.m_data),  0);
    check("rst_m_ch",    32'(bus.m_ch),    0);
    check("rst_s_ready", 32'(bus.s_ready), 0);
    @(negedge clk) rst_n = 1'b1;

`ifdef STREAM_MUX_LOCK_EN
    // ch0 sends a 3-beat packet while ch1 is always valid; mode flips mid-packet
    begin
      bit [1:0] exp_ch[4]  = '{0, 0, 0, 1};
      bit       exp_lst[4] = '{0, 0, 1, 1};
      bit [3:0] exp_rd[4]  = '{4'b0001, 4'b0001, 4'b0001, 4'b0010};
      for (int b = 0; b < 4; b++) begin
        @(negedge clk);
        mode = (b == 0) ? 1'b1 : 1'b0; sel = 2'd1;
        bus.s_valid = 4'b0011; bus.m_ready = 1'b1;
        bus.s_last  = {3'b111, (b == 2) ? 1'b1 : 1'b0};
        #1 check($sformatf("lock%0d_s_ready", b), 32'(bus.s_ready), 32'(exp_rd[b]));
        @(posedge clk); #1;
        check($sformatf("lock%0d_m_ch", b),   32'(bus.m_ch),   32'(exp_ch[b]));
        check($sformatf("lock%0d_m_last", b), 32'(bus.m_last), 32'(exp_lst[b]));
      end
      @(negedge clk);
      bus.s_last = '1;
      rst_n = 1'b0;
      @(negedge clk) rst_n = 1'b1;
    end
`endif

    // Randomized traffic against the reference model
    m_mv = 0; m_ch = 0; m_ptr = 0; m_data = 8'h00;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      mode = 1'($urandom_range(0, 1));
      sel  = 2'($urandom_range(0, 3));
      bus.s_valid = 4'($urandom_range(0, 15));
      bus.m_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < N; i++) chan_data[i] = 8'($urandom);
      drive_data();
      g       = model_grant(mode, int'(sel), bus.s_valid, m_ptr);
      load    = !m_mv || bus.m_ready;
      exp_rdy = (load && g >= 0) ? (4'b0001 << g) : 4'b0000;
      #1 check("rnd_s_ready", 32'(bus.s_ready), 32'(exp_rdy));
      @(posedge clk);
      if (load && g >= 0) begin
        m_mv = 1; m_ch = g; m_data = chan_data[g];
        if (mode) m_ptr = (g + 1) % N;
      end else if (bus.m_ready) begin
        m_mv = 0;
      end
      #1;
      check("rnd_m_valid", 32'(bus.m_valid), 32'(m_mv));
      check("rnd_m_ch",    32'(bus.m_ch),    32'(m_ch));
      check("rnd_m_data",  32'(bus.m_data),  32'(m_data));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
